// File: rtl/lsq_param_pkg.sv
// Shared encodings for the parametrised load/store queue: memory ops, access sizes,
// load/store kinds and the head-FSM state type.
package lsq_param_pkg;

    localparam int unsigned OP_LOG = 3;

    localparam logic [OP_LOG-1:0] OP_LB  = 3'd0;
    localparam logic [OP_LOG-1:0] OP_LH  = 3'd1;
    localparam logic [OP_LOG-1:0] OP_LW  = 3'd2;
    localparam logic [OP_LOG-1:0] OP_LBU = 3'd3;
    localparam logic [OP_LOG-1:0] OP_LHU = 3'd4;
    localparam logic [OP_LOG-1:0] OP_SB  = 3'd5;
    localparam logic [OP_LOG-1:0] OP_SH  = 3'd6;
    localparam logic [OP_LOG-1:0] OP_SW  = 3'd7;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    localparam logic KIND_LOAD  = 1'b0;
    localparam logic KIND_STORE = 1'b1;

    typedef enum logic {StIdle, StWait} head_state_e;

    function automatic logic op_kind(input logic [OP_LOG-1:0] op);
        return (op >= OP_SB) ? KIND_STORE : KIND_LOAD;
    endfunction

    function automatic logic [2:0] op_size(input logic [OP_LOG-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_B;
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            default:              return SIZE_W;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [OP_LOG-1:0] op,
                                                input logic [31:0] rdata);
        case (op)
            OP_LB:   return {{24{rdata[7]}}, rdata[7:0]};
            OP_LH:   return {{16{rdata[15]}}, rdata[15:0]};
            OP_LBU:  return {24'b0, rdata[7:0]};
            OP_LHU:  return {16'b0, rdata[15:0]};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/lsq_operand_snoop.sv
// Compares one operand tag against every broadcast source; the lowest-numbered matching
// source supplies the value.
module lsq_operand_snoop #(
    parameter int unsigned N_SRC = 3,
    parameter int unsigned ROB_W = 4
) (
    input  logic [ROB_W-1:0]       tag,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [N_SRC*ROB_W-1:0] src_rob,
    input  logic [N_SRC*32-1:0]    src_value,
    output logic                   hit,
    output logic [31:0]            value
);

    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!hit && src_valid[i] && (src_rob[i*ROB_W +: ROB_W] == tag)) begin
                hit   = 1'b1;
                value = src_value[i*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/lsq_param.sv
// In-order load/store queue between dispatch, ROB, CDB and the memory controller, with
// operand snooping, store-ready notification and precise flush.
module lsq_param
    import lsq_param_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ROB_W       = 4,
    parameter int unsigned N_CDB       = 2,
    parameter int unsigned AFULL_SLACK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       issue_valid,
    input  logic [OP_LOG-1:0]          issue_op,
    input  logic [31:0]                issue_vj,
    input  logic [31:0]                issue_vk,
    input  logic                       issue_rj,
    input  logic                       issue_rk,
    input  logic [ROB_W-1:0]           issue_qj,
    input  logic [ROB_W-1:0]           issue_qk,
    input  logic [31:0]                issue_imm,
    input  logic [ROB_W-1:0]           issue_rob,
    input  logic                       commit_valid,
    input  logic [ROB_W-1:0]           commit_rob,
    input  logic [N_CDB-1:0]           cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]     cdb_rob,
    input  logic [N_CDB*32-1:0]        cdb_value,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [2:0]                 mem_size,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_done,
    input  logic [31:0]                mem_rdata,
    output logic                       ld_valid,
    output logic [ROB_W-1:0]           ld_rob,
    output logic [31:0]                ld_value,
    output logic                       st_ready_valid,
    output logic [ROB_W-1:0]           st_ready_rob,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned N_SRC = N_CDB + 1;
    localparam logic [CNT_W-1:0] FULL_AT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_AT = CNT_W'(DEPTH - AFULL_SLACK);

    logic [DEPTH-1:0]  e_valid, e_committed, e_notified, e_rj, e_rk;
    logic [OP_LOG-1:0] e_op  [DEPTH];
    logic [31:0]       e_vj  [DEPTH];
    logic [31:0]       e_vk  [DEPTH];
    logic [31:0]       e_imm [DEPTH];
    logic [ROB_W-1:0]  e_qj  [DEPTH];
    logic [ROB_W-1:0]  e_qk  [DEPTH];
    logic [ROB_W-1:0]  e_rob [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    head_state_e      state_q;
    logic             killed_q;

    // The queue's own load result is a snoop source alongside the CDB ports.
    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC*ROB_W-1:0] src_rob;
    logic [N_SRC*32-1:0]    src_value;
    assign src_valid = {ld_valid, cdb_valid};
    assign src_rob   = {ld_rob, cdb_rob};
    assign src_value = {ld_value, cdb_value};

    logic [DEPTH-1:0] hit_j, hit_k;
    logic [31:0]      val_j [DEPTH];
    logic [31:0]      val_k [DEPTH];
    logic             iss_hit_j, iss_hit_k;
    logic [31:0]      iss_val_j, iss_val_k;

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_snoop
        lsq_operand_snoop #(.N_SRC(N_SRC), .ROB_W(ROB_W)) u_j (
            .tag(e_qj[g]), .src_valid(src_valid), .src_rob(src_rob),
            .src_value(src_value), .hit(hit_j[g]), .value(val_j[g]));
        lsq_operand_snoop #(.N_SRC(N_SRC), .ROB_W(ROB_W)) u_k (
            .tag(e_qk[g]), .src_valid(src_valid), .src_rob(src_rob),
            .src_value(src_value), .hit(hit_k[g]), .value(val_k[g]));
    end

    lsq_operand_snoop #(.N_SRC(N_SRC), .ROB_W(ROB_W)) u_iss_j (
        .tag(issue_qj), .src_valid(src_valid), .src_rob(src_rob),
        .src_value(src_value), .hit(iss_hit_j), .value(iss_val_j));
    lsq_operand_snoop #(.N_SRC(N_SRC), .ROB_W(ROB_W)) u_iss_k (
        .tag(issue_qk), .src_valid(src_valid), .src_rob(src_rob),
        .src_value(src_value), .hit(iss_hit_k), .value(iss_val_k));

    logic             head_ready, head_is_store, enq, deq, notify_hit;
    logic [PTR_W-1:0] notify_idx, scan_idx, head_d, tail_d;
    logic [CNT_W-1:0] committed_cnt, count_d;

    always_comb begin
        head_ready    = e_valid[head_q] && e_rj[head_q] && e_rk[head_q];
        head_is_store = (op_kind(e_op[head_q]) == KIND_STORE);
        enq           = issue_valid && !flush && (count != FULL_AT);
        // A killed load's entry is already gone; a flush drops an uncommitted head outright.
        deq = (state_q == StWait) && mem_done && !killed_q && !(flush && !e_committed[head_q]);

        committed_cnt = '0;
        notify_hit    = 1'b0;
        notify_idx    = '0;
        scan_idx      = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            committed_cnt = committed_cnt + CNT_W'(e_valid[i] & e_committed[i]);
            scan_idx = head_q + PTR_W'(i);
            if (!notify_hit && e_valid[scan_idx] && (op_kind(e_op[scan_idx]) == KIND_STORE) &&
                e_rj[scan_idx] && e_rk[scan_idx] && !e_notified[scan_idx]) begin
                notify_hit = 1'b1;
                notify_idx = scan_idx;
            end
        end

        head_d = deq ? head_q + PTR_W'(1) : head_q;
        if (flush) begin
            tail_d  = head_q + PTR_W'(committed_cnt);
            count_d = committed_cnt - CNT_W'(deq);
        end else begin
            tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
            count_d = count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count          <= '0;
            almost_full    <= 1'b0;
            state_q        <= StIdle;
            killed_q       <= 1'b0;
            e_valid        <= '0;
            e_committed    <= '0;
            e_notified     <= '0;
            e_rj           <= '0;
            e_rk           <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_size       <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            ld_valid       <= 1'b0;
            ld_rob         <= '0;
            ld_value       <= '0;
            st_ready_valid <= 1'b0;
            st_ready_rob   <= '0;
        end else if (rdy) begin
            ld_valid       <= 1'b0;
            st_ready_valid <= 1'b0;

            for (int i = 0; i < int'(DEPTH); i++) begin
                if (e_valid[i] && !e_rj[i] && hit_j[i]) begin
                    e_vj[i] <= val_j[i];
                    e_rj[i] <= 1'b1;
                end
                if (e_valid[i] && !e_rk[i] && hit_k[i]) begin
                    e_vk[i] <= val_k[i];
                    e_rk[i] <= 1'b1;
                end
                if (commit_valid && !flush && e_valid[i] && (e_rob[i] == commit_rob)) begin
                    e_committed[i] <= 1'b1;
                end
            end

            if (notify_hit && !flush) begin
                st_ready_valid         <= 1'b1;
                st_ready_rob           <= e_rob[notify_idx];
                e_notified[notify_idx] <= 1'b1;
            end

            if (enq) begin
                e_valid[tail_q]     <= 1'b1;
                e_committed[tail_q] <= 1'b0;
                e_notified[tail_q]  <= 1'b0;
                e_op[tail_q]        <= issue_op;
                e_imm[tail_q]       <= issue_imm;
                e_rob[tail_q]       <= issue_rob;
                e_qj[tail_q]        <= issue_qj;
                e_qk[tail_q]        <= issue_qk;
                e_vj[tail_q]        <= (!issue_rj && iss_hit_j) ? iss_val_j : issue_vj;
                e_vk[tail_q]        <= (!issue_rk && iss_hit_k) ? iss_val_k : issue_vk;
                e_rj[tail_q]        <= issue_rj || iss_hit_j;
                e_rk[tail_q]        <= issue_rk || iss_hit_k;
            end

            if (flush) e_valid <= e_valid & e_committed;
            if (deq) e_valid[head_q] <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!flush && head_ready && (!head_is_store || e_committed[head_q])) begin
                        state_q   <= StWait;
                        mem_req   <= 1'b1;
                        mem_we    <= head_is_store;
                        mem_size  <= op_size(e_op[head_q]);
                        mem_addr  <= e_vj[head_q] + e_imm[head_q];
                        mem_wdata <= e_vk[head_q];
                    end
                end
                StWait: begin
                    if (mem_done) begin
                        state_q  <= StIdle;
                        mem_req  <= 1'b0;
                        killed_q <= 1'b0;
                        if (deq && !head_is_store) begin
                            ld_valid <= 1'b1;
                            ld_rob   <= e_rob[head_q];
                            ld_value <= load_extend(e_op[head_q], mem_rdata);
                        end
                    end else if (flush && !e_committed[head_q]) begin
                        killed_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            head_q      <= head_d;
            tail_q      <= tail_d;
            count       <= count_d;
            almost_full <= (count_d >= AFULL_AT);
        end
    end

endmodule
